alu_nibble_seq: RTL and testbench
=================================

# alu_nibble_seq

Sequencer that executes WIDTH-bit add/sub/AND/OR operations by streaming operands one 4-bit nibble per cycle through a single 4-bit ALU slice. Nibbles run LSB first, and the carry is registered between nibbles. The block sits between a requester (valid/ready operation port) and a consumer (valid/ready result port). This lets the design run wide arithmetic on the existing 4-bit datapath width.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
- NIB, WIDTH/4, derived nibble count (localparam, not overridable)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request
- in_opcode  in  2  00 add, 01 sub, 10 AND, 11 OR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; used by add only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_cout  out  1  final carry (add/sub), 0 for AND/OR
- out_zero  out  1  result == 0; present only with ALU_SEQ_ZERO_FLAG_EN

## Operation
- FSM states and transitions:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE after nibble NIB-1 is processed.
  - DONE → IDLE on out_valid & out_ready.
- Signal decodes: in_ready = (state==IDLE); out_valid = (state==DONE).
- On accept, latch opcode, A, B and a nibble counter = 0.
- Initial carry register on accept:
  - add: in_cin
  - sub: 1
  - AND/OR: 0
- Each RUN cycle, the slice takes A[4k+3:4k], B' nibble and carry. It writes result nibble k, stores the slice carry-out and increments k.
- B' = ~B for sub, B otherwise. Sub computes A + ~B + 1 modulo 2^WIDTH, so out_cout=1 means no borrow (A ≥ B unsigned).
- AND/OR: slice carry-out forced 0, so out_cout=0.
- Result register fills progressively. Only the value presented while out_valid=1 is defined for the consumer.
- out_result and out_cout hold stable while out_valid & ~out_ready.
- in_valid is ignored outside IDLE; there is no queueing.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, out_cout 0, out_zero 0, counter 0, carry 0.
- rst asserted mid-RUN or in DONE aborts the operation; the result is discarded and nothing is emitted.

## Timing
- Accept edge E0; nibbles processed on edges E1..E_NIB.
- out_valid rises after E_NIB, i.e. NIB cycles after accept (4 for WIDTH=16).
- Minimum issue interval is NIB+2 cycles: NIB RUN cycles, ≥1 DONE cycle, 1 IDLE cycle.
- in_ready is low from the cycle after accept until the cycle after the output handshake. There is no same-cycle DONE→accept bypass.
- Outputs are registered, except in_ready/out_valid, which decode the registered state.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined:
  - out_zero port exists.
  - A sticky "any nonzero nibble" register is cleared on accept and ORed with each result nibble.
  - out_zero = ~sticky, valid with out_valid and held with result.
- Undefined: port and register are absent; all other behaviour is identical.

## Structure
- Package alu_seq_pkg holds:
  - opcode typedef (OP_ADD, OP_SUB, OP_AND, OP_OR)
  - state typedef (S_IDLE, S_RUN, S_DONE)
  - NIBBLE_W = 4
- One sub-module, alu_slice4: combinational 4-bit slice taking (a, b', opcode, cin) and returning (result, cout), per the rules above.
- The top holds the FSM, counter, carry register, operand/result registers and the optional zero-flag logic.

## Test plan
- Add 0x1234 + 0x0FFF, cin=0 → 0x2233, cout=0; out_valid exactly 4 cycles after accept.
- Add 0xFFFF + 0x0001, cin=0 → 0x0000, cout=1, out_zero=1 (with macro).
- Sub 0x0007 − 0x0005 → 0x0002, cout=1; sub 0x0005 − 0x0007 → 0xFFFE, cout=0.
- AND 0xF0F0 & 0x3C3C → 0x3030, cout=0; OR same operands → 0xFCFC, cout=0, even with in_cin=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → result stable, in_ready=0, no second accept; next accept occurs 1 cycle after the output handshake.
- Assert rst during the 2nd RUN cycle → out_valid=0, in_ready=1, out_result=0 immediately; no result emitted afterwards.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the nibble-serial ALU sequencer
//
// Purpose: opcode and FSM state encodings, the slice width, and the helper
//          that picks the carry loaded when an operation is accepted.
// Ports:   none (package).
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Sub is A + ~B + 1, so the "+1" enters as the initial carry.
  function automatic logic init_carry(input logic [1:0] opcode, input logic cin);
    logic c;
    c = 1'b0;
    case (opcode)
      OP_ADD:  c = cin;
      OP_SUB:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_slice4.sv
// rtl/alu_slice4.sv - combinational 4-bit ALU slice
//
// Purpose: one nibble of add/sub/AND/OR. For sub the caller supplies the
//          already inverted B nibble, so add and sub share the adder.
// Ports:
//   a_i      in  4  operand A nibble
//   b_i      in  4  operand B' nibble (inverted B for sub)
//   opcode_i in  2  operation (alu_seq_pkg::opcode_e encoding)
//   cin_i    in  1  carry into this nibble
//   result_o out 4  result nibble
//   cout_o   out 1  carry out (forced 0 for AND/OR)
module alu_slice4
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic [1:0]          opcode_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] result_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
    result_o = sum[NIBBLE_W-1:0];
    cout_o   = sum[NIBBLE_W];
    case (opcode_i)
      OP_AND: begin
        result_o = a_i & b_i;
        cout_o   = 1'b0;
      end
      OP_OR: begin
        result_o = a_i | b_i;
        cout_o   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - WIDTH-bit add/sub/AND/OR run one nibble per cycle
//
// Purpose: accepts an operation, streams operands LSB nibble first through a
//          single alu_slice4 with a registered carry, then presents the result
//          until the consumer takes it.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operation request valid
//   in_ready   out 1      idle, can accept a request
//   in_opcode  in  2      00 add, 01 sub, 10 AND, 11 OR
//   in_a       in  WIDTH  operand A
//   in_b       in  WIDTH  operand B
//   in_cin     in  1      carry-in (add only)
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer accepts result
//   out_result out WIDTH  result
//   out_cout   out 1      final carry (add/sub), 0 for AND/OR
//   out_zero   out 1      result == 0 (only with ALU_SEQ_ZERO_FLAG_EN)
// Build option: ALU_SEQ_ZERO_FLAG_EN adds out_zero and its sticky register.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [1:0]         opcode_q, opcode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic               run;
  logic               last_nib;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_res;
  logic               slice_cout;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign run      = (state_q == S_RUN);
  assign last_nib = (cnt_q == LAST_NIB);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_nib)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign slice_a = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  alu_slice4 u_slice (
    .a_i      (slice_a),
    .b_i      (slice_b),
    .opcode_i (opcode_q),
    .cin_i    (carry_q),
    .result_o (slice_res),
    .cout_o   (slice_cout)
  );

  always_comb begin
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    if (accept) begin
      opcode_d = in_opcode;
      a_d      = in_a;
      // B is stored pre-inverted for sub so the slice only ever adds.
      b_d      = (in_opcode == OP_SUB) ? ~in_b : in_b;
      cnt_d    = '0;
      carry_d  = init_carry(in_opcode, in_cin);
    end else if (run) begin
      res_d[cnt_q*NIBBLE_W +: NIBBLE_W] = slice_res;
      carry_d = slice_cout;
      cnt_d   = last_nib ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  // After the last nibble the carry register holds the final carry and is
  // left untouched through DONE, so it doubles as out_cout.
  assign out_result = res_q;
  assign out_cout   = carry_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (accept)   sticky_d = 1'b0;
    else if (run) sticky_d = sticky_q | (|slice_res);
  end

  // Resets to "nonzero seen" so out_zero reads low until a result exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b1;
    else     sticky_q <= sticky_d;
  end

  assign out_zero = ~sticky_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - self-checking bench for alu_nibble_seq
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic, {cout, result}
  function automatic logic [WIDTH:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  task automatic check_res(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] e;
    e = model(op, a, b, cin);
    check("result", 32'(out_result), 32'(e[WIDTH-1:0]));
    check("cout", 32'(out_cout), 32'(e[WIDTH]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("zero", 32'(out_zero), 32'(e[WIDTH-1:0] == '0));
`endif
  endtask

  task automatic start(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, input bit keep);
    check("pre_rdy", 32'(in_ready), 32'd1);
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_valid  = 1'b1;
    tick();
    if (!keep) in_valid = 1'b0;
    check("acc_rdy_low", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(NIB));
  endtask

  task automatic hold(input int n, input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic cin);
    for (int i = 0; i < n; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_rdy", 32'(in_ready), 32'd0);
      check_res(op, a, b, cin);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, input int h);
    start(op, a, b, cin, 1'b0);
    wait_done();
    check_res(op, a, b, cin);
    hold(h, op, a, b, cin);
    handshake();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cin;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("rst_zero", 32'(out_zero), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1);
    do_op(OP_SUB, 16'h0007, 16'h0005, 1'b0, 0);
    do_op(OP_SUB, 16'h0005, 16'h0007, 1'b0, 0);
    do_op(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 0);
    do_op(OP_OR,  16'hF0F0, 16'h3C3C, 1'b1, 0);
    do_op(OP_SUB, 16'hBEEF, 16'hBEEF, 1'b0, 0);

    // Backpressure with in_valid held high the whole time
    start(OP_ADD, 16'hA5A5, 16'h1234, 1'b1, 1'b1);
    wait_done();
    check_res(OP_ADD, 16'hA5A5, 16'h1234, 1'b1);
    hold(3, OP_ADD, 16'hA5A5, 16'h1234, 1'b1);
    handshake();
    tick();
    check("reaccept_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_done();
    check_res(OP_ADD, 16'hA5A5, 16'h1234, 1'b1);
    handshake();

    // Reset during the second RUN cycle
    start(OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_rdy", 32'(in_ready), 32'd1);
    check("abort_result", 32'(out_result), 32'd0);
    check("abort_cout", 32'(out_cout), 32'd0);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_emit", 32'(seen), 32'd0);

    // Randomized operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = WIDTH'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? a : WIDTH'($urandom);
      cin = 1'($urandom);
      do_op(op, a, b, cin, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
